// File: rtl/bus_arbiter_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
package bus_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 17;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_CPU   = 2'd1,
    GRANT_VIDEO = 2'd2,
    GRANT_SPI   = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

endpackage

// File: rtl/bus_arb_select.sv
// Fixed-priority requester select (CPU > video > SPI) with an SPI starvation override.
module bus_arb_select
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk_sys_i,
  input  logic   reset,
  input  logic   arb_idle,
  input  logic   grant_now,
  input  logic   cpu_valid,
  input  logic   video_valid,
  input  logic   spi_valid,
  output grant_t grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    grant = GRANT_NONE;
    if (spi_valid && starve_cnt == LIMIT) grant = GRANT_SPI;
    else if (cpu_valid)                   grant = GRANT_CPU;
    else if (video_valid)                 grant = GRANT_VIDEO;
    else if (spi_valid)                   grant = GRANT_SPI;
  end

  // Counts CPU/video wins that SPI sat through; an IDLE cycle without SPI pending forgives it.
  always_ff @(posedge clk_sys_i or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_idle) begin
      if (!spi_valid) begin
        starve_cnt <= '0;
      end else if (grant_now) begin
        if (grant == GRANT_SPI)      starve_cnt <= '0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Three-way SRAM port arbiter sequencing each access as SETUP, STROBE, HOLD with registered pins.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk_sys_i,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [ADDR_WIDTH-1:0] video_addr_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  input  logic [DATA_WIDTH-1:0] spi_data_i,
  input  logic                  cpu_rw_ni,
  input  logic                  spi_rw_ni,
  input  logic                  cpu_valid_i,
  input  logic                  video_valid_i,
  input  logic                  spi_valid_i,
  output logic                  cpu_ready_o,
  output logic                  video_ready_o,
  output logic                  spi_ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  ram_data_oe_o,
  output logic                  ram_oe_no,
  output logic                  ram_we_no,
  output logic [1:0]            grant_o
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t                state, state_nxt;
  grant_t                grant_q, grant_nxt, sel;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  rw_n, rw_nxt;
  logic                  grant_now, arb_idle;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] data_nxt, rdata_nxt;
  logic                  oe_n_nxt, we_n_nxt, doe_nxt;
  logic [2:0]            rdy_q, rdy_nxt;

  assign arb_idle      = (state == IDLE);
  assign grant_o       = grant_q;
  assign cpu_ready_o   = rdy_q[0];
  assign video_ready_o = rdy_q[1];
  assign spi_ready_o   = rdy_q[2];

  bus_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk_sys_i  (clk_sys_i),
    .reset      (reset),
    .arb_idle   (arb_idle),
    .grant_now  (grant_now),
    .cpu_valid  (cpu_valid_i),
    .video_valid(video_valid_i),
    .spi_valid  (spi_valid_i),
    .grant      (sel)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    cnt_nxt   = cnt;
    rw_nxt    = rw_n;
    addr_nxt  = ram_addr_o;
    data_nxt  = ram_data_o;
    rdata_nxt = rdata_o;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    doe_nxt   = ram_data_oe_o;
    rdy_nxt   = 3'b000;
    grant_now = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_valid_i || video_valid_i || spi_valid_i) begin
          grant_now = 1'b1;
          grant_nxt = sel;
          state_nxt = SETUP;
          case (sel)
            GRANT_CPU:   begin addr_nxt = cpu_addr_i;   data_nxt = cpu_data_i; rw_nxt = cpu_rw_ni; end
            GRANT_VIDEO: begin addr_nxt = video_addr_i; rw_nxt = 1'b1; end
            GRANT_SPI:   begin addr_nxt = spi_addr_i;   data_nxt = spi_data_i; rw_nxt = spi_rw_ni; end
            default: ;
          endcase
          doe_nxt = !rw_nxt;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LOAD;
        oe_n_nxt  = !rw_n;
        we_n_nxt  = rw_n;
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          if (rw_n) rdata_nxt = ram_data_i;
          case (grant_q)
            GRANT_CPU:   rdy_nxt = 3'b001;
            GRANT_VIDEO: rdy_nxt = 3'b010;
            GRANT_SPI:   rdy_nxt = 3'b100;
            default: ;
          endcase
        end else begin
          cnt_nxt  = cnt - 1'b1;
          oe_n_nxt = !rw_n;
          we_n_nxt = rw_n;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        grant_nxt = GRANT_NONE;
        doe_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every pin comes straight from a flop; reset parks the bus with strobes high and the driver off.
  always_ff @(posedge clk_sys_i or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant_q       <= GRANT_NONE;
      cnt           <= '0;
      rw_n          <= 1'b1;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      rdata_o       <= '0;
      ram_oe_no     <= 1'b1;
      ram_we_no     <= 1'b1;
      ram_data_oe_o <= 1'b0;
      rdy_q         <= 3'b000;
    end else begin
      state         <= state_nxt;
      grant_q       <= grant_nxt;
      cnt           <= cnt_nxt;
      rw_n          <= rw_nxt;
      ram_addr_o    <= addr_nxt;
      ram_data_o    <= data_nxt;
      rdata_o       <= rdata_nxt;
      ram_oe_no     <= oe_n_nxt;
      ram_we_no     <= we_n_nxt;
      ram_data_oe_o <= doe_nxt;
      rdy_q         <= rdy_nxt;
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single external SRAM port between three requesters: the CPU, video fetch, and the SPI bridge. Each requester uses a valid/ready handshake. It holds addr, wdata and rw_n stable with valid high, and receives a one-cycle ready pulse when the access completes. The block sequences each access through setup, strobe and hold phases and drives the RAM control lines. It sits between the requesters and the top-level SRAM pins.

Parameters:
ADDR_WIDTH, 17, width of RAM address (A16..A0)
DATA_WIDTH, 8, RAM data width
ACCESS_CYCLES, 2, number of clk_sys_i cycles the OE/WE strobe is held low (legal range >=1)
STARVE_LIMIT, 4, consecutive CPU/video grants while SPI waits before SPI is forced to win (legal range >=1)

Ports:
clk_sys_i  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_addr_i / video_addr_i / spi_addr_i  in  ADDR_WIDTH each  request address
cpu_data_i / spi_data_i  in  DATA_WIDTH each  write data (video is read-only)
cpu_rw_ni / spi_rw_ni  in  1 each  1=read, 0=write
cpu_valid_i / video_valid_i / spi_valid_i  in  1 each  request pending
cpu_ready_o / video_ready_o / spi_ready_o  out  1 each  one-cycle completion pulse
rdata_o  out  DATA_WIDTH  last read data; valid in the ready cycle and held after
ram_addr_o  out  ADDR_WIDTH  SRAM address
ram_data_o  out  DATA_WIDTH  SRAM write data
ram_data_i  in  DATA_WIDTH  SRAM read data
ram_data_oe_o  out  1  enables the top-level tristate driver for ram_data_o
ram_oe_no  out  1  SRAM output enable, active low
ram_we_no  out  1  SRAM write enable, active low
grant_o  out  2  current owner (debug): 0 none, 1 cpu, 2 video, 3 spi

Behaviour:
- Reset (async, takes effect immediately, including mid-access):
  - state IDLE;
  - ram_oe_no = ram_we_no = 1; ram_data_oe_o = 0;
  - all ready_o = 0; grant_o = 0;
  - rdata_o, ram_addr_o, ram_data_o = 0;
  - starvation counter = 0.
  - Any in-flight access is abandoned with no ready pulse.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - If any valid is high, pick a winner, latch its addr/data/rw_n into ram_addr_o/ram_data_o/internal rw, set grant_o, then go to SETUP.
  - Requester inputs are sampled only in IDLE; later changes are ignored.
- Arbitration priority: CPU > video > SPI.
  - Exception: if starve_cnt == STARVE_LIMIT and spi_valid_i is high, SPI wins.
  - starve_cnt increments (saturating) on each CPU/video grant made while spi_valid_i is high.
  - starve_cnt clears on an SPI grant, or in any IDLE cycle with spi_valid_i low.
- SETUP (1 cycle):
  - Address is stable; strobes stay high.
  - On a write, ram_data_oe_o = 1 from this cycle through HOLD inclusive.
  - Load the strobe counter with ACCESS_CYCLES-1.
- STROBE (ACCESS_CYCLES cycles):
  - Read: ram_oe_no = 0. Write: ram_we_no = 0.
  - Counter decrements each cycle; at 0 go to HOLD.
  - On a read, capture ram_data_i into rdata_o at the clock edge leaving the last STROBE cycle.
- HOLD (1 cycle):
  - Strobes high; address and write data held.
  - Granted requester's ready_o = 1 for exactly this cycle.
  - Next state IDLE; grant_o returns to 0.
- Latency: valid seen in IDLE at cycle t gives ready high at cycle t+2+ACCESS_CYCLES. Minimum access period is 3+ACCESS_CYCLES cycles.
- Requesters must deassert valid on the edge that samples ready. A valid still high in the following IDLE cycle is treated as a new request.
- Valid dropped mid-access is a protocol violation: the access completes and ready still pulses.
- Simultaneous requests: losers keep valid high and are served in later IDLE cycles. No request is lost.
- ram_oe_no and ram_we_no are never low in the same cycle. ram_we_no never falls in the same cycle ram_addr_o changes.
- All outputs are registered.

Decomposition:
- Package bus_arbiter_pkg:
  - grant_t enum (GRANT_NONE=0, GRANT_CPU=1, GRANT_VIDEO=2, GRANT_SPI=3);
  - state_t enum (IDLE, SETUP, STROBE, HOLD);
  - shared ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module bus_arb_select: holds the priority logic and the starvation counter. It takes the valids plus a "grant now" strobe from the FSM and returns grant_t.

Test Plan:
- Read timing: ACCESS_CYCLES=2, spi_valid_i=1, spi_rw_ni=1, spi_addr_i=17'h1_2345, RAM model returns 8'hA5. Required:
  - ram_addr_o=1_2345;
  - ram_oe_no low for exactly 2 cycles;
  - spi_ready_o high 1 cycle at t+4;
  - rdata_o=A5;
  - ram_we_no stays 1.
- Write timing: cpu_valid_i=1, cpu_rw_ni=0, addr 17'h0_8000, data 8'h3C. Required:
  - ram_we_no low 2 cycles;
  - ram_data_oe_o high SETUP..HOLD (4 cycles);
  - RAM model holds 3C at 8000;
  - cpu_ready_o pulses once.
- Contention: cpu, video and spi valid together in the same cycle. Required grant order is CPU, video, SPI on successive accesses, each ready pulsing once.
- Starvation: CPU and video request continuously, SPI valid held high. Required: SPI is granted on the 5th arbitration (STARVE_LIMIT=4), then the counter clears.
- Reset mid-access: assert reset during STROBE of a write. Required:
  - ram_we_no=1 and ram_data_oe_o=0 immediately (same cycle, asynchronous);
  - no ready pulse;
  - after release, state IDLE and a new request completes normally.
- Back-to-back: video_valid_i stays high after ready. Required: a second access starts in the next IDLE cycle, giving a period of exactly 5 cycles with ACCESS_CYCLES=2.
